// File: rtl/riscv_pkg.sv
// Shared front-end definitions: data width, EBREAK encoding and fetch FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  // EBREAK instruction word; fetching it parks the front end in HALT.
  localparam logic [XLEN-1:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched {instruction, pc} pairs.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle. Flush empties the FIFO and wins over push/pop.
// rdata is forced to zero while empty so downstream sees clean outputs.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because empty masks the output.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC register, fetch FSM and a small fetch buffer.
// Optional build macro FETCH_PERF_CNT_EN adds fetchCount/stallCount outputs.
//
// Decode handshake: instrValid is high whenever the buffer holds an entry;
// a transfer happens on a rising edge where instrValid && instrReady, and
// while instrValid && !instrReady the instr/instrPC pair is held unchanged.
// instrValid never depends combinationally on instrReady.
module fetch_controller
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
  parameter int              IMEM_WORDS = 256,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectPC,
  output logic [XLEN-1:0] imemAddr,
  input  logic [XLEN-1:0] imemData,
  output logic            instrValid,
  input  logic            instrReady,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instrPC,
  output logic            halted,
  output logic            fault,
  output fetch_state_e    state_dbg
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetchCount,
  output logic [31:0]     stallCount
`endif
);

  // Byte size of instruction memory, one bit wider so it cannot overflow.
  localparam logic [XLEN:0] IMEM_BYTES = {1'b0, 32'(IMEM_WORDS)} << 2;

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       pc_d;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [2*XLEN-1:0]     fifo_rdata;
  logic                  pc_illegal;

  assign pc_illegal = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= IMEM_BYTES);
  assign pop        = instrReady && !fifo_empty;

  assign imemAddr   = pc_q;
  assign instrValid = !fifo_empty;
  assign instr      = fifo_rdata[2*XLEN-1:XLEN];
  assign instrPC    = fifo_rdata[XLEN-1:0];
  assign halted     = (state_q == ST_HALT);
  assign fault      = (state_q == ST_FAULT);
  assign state_dbg  = state_q;

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic: redirect beats the fault check, which beats EBREAK and fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirectValid && (state_q != ST_FAULT)) begin
      flush   = 1'b1;
      pc_d    = redirectPC;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pc_illegal) begin
            state_d = ST_FAULT;
          end else if (!fifo_full || pop) begin
            push = 1'b1;
            // EBREAK is still delivered, but the PC stays pointing at it.
            if (imemData == EBREAK_INSN) state_d = ST_HALT;
            else                         pc_d    = pc_q + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({imemData, pc_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  // Capture and stall counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      fetchCount <= fetchCount + {31'b0, push};
      stallCount <= stallCount + {31'b0, (state_q == ST_RUN) && fifo_full && !pop};
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: instruction memory model, expected-entry queue
// checked whenever decode accepts an instruction, plus directed state checks.
module tb_fetch_controller;
  import riscv_pkg::*;

  localparam int IMEM_WORDS = 256;
  localparam logic [31:0] I0   = 32'h0050_0113;
  localparam logic [31:0] I1   = 32'h0030_0193;
  localparam logic [31:0] I2   = 32'h0031_00b3;
  localparam logic [31:0] I3   = 32'h4031_0133;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         redirectValid = 1'b0;
  logic [31:0]  redirectPC = 32'h0;
  logic         instrReady = 1'b0;
  logic [31:0]  imemAddr;
  logic [31:0]  imemData;
  logic         instrValid;
  logic [31:0]  instr;
  logic [31:0]  instrPC;
  logic         halted;
  logic         fault;
  fetch_state_e state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  fetchCount;
  logic [31:0]  stallCount;
`endif

  logic [31:0]  mem [IMEM_WORDS];
  logic [63:0]  exp_q[$];
  int           assert_cnt = 0;
  int           fail_cnt = 0;

  fetch_controller #(
    .RESET_PC   (32'h0),
    .IMEM_WORDS (IMEM_WORDS),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .redirectValid (redirectValid),
    .redirectPC    (redirectPC),
    .imemAddr      (imemAddr),
    .imemData      (imemData),
    .instrValid    (instrValid),
    .instrReady    (instrReady),
    .instr         (instr),
    .instrPC       (instrPC),
    .halted        (halted),
    .fault         (fault),
    .state_dbg     (state_dbg)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetchCount    (fetchCount),
    .stallCount    (stallCount)
`endif
  );

  // Clock and combinational instruction memory.
  always #5 clk = ~clk;
  assign imemData = (imemAddr < 32'd1024) ? mem[imemAddr[9:2]] : 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && instrValid && instrReady) begin
      if (exp_q.size() == 0) check("sb_extra", 64'({instr, instrPC}), 64'hdead_dead_dead_dead);
      else                   check("sb_instr", 64'({instr, instrPC}), exp_q.pop_front());
    end
  end

  // Inputs change just after the rising edge; outputs are read just after the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirectValid = 1'b0; redirectPC = 32'h0; instrReady = 1'b0;
    #1;
    exp_q.delete();
    check("rst_valid",  64'(instrValid), 64'(0));
    check("rst_instr",  64'(instr),      64'(0));
    check("rst_ipc",    64'(instrPC),    64'(0));
    check("rst_addr",   64'(imemAddr),   64'(0));
    check("rst_halted", 64'(halted),     64'(0));
    check("rst_fault",  64'(fault),      64'(0));
    check("rst_state",  64'(state_dbg),  64'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_prog(input bit ebreak_at2);
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = {25'($urandom_range(1, 33554431)), 7'h13};
    mem[0] = I0; mem[1] = I1; mem[2] = ebreak_at2 ? EBRK : I2; mem[3] = I3; mem[4] = EBRK;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) smp();
    check("halt_reached", 64'(halted), 64'(1));
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      step();
      if (rnd) instrReady = 1'($urandom_range(0, 1));
    end
    step();
    smp();
    check("drain_empty",   64'(exp_q.size()), 64'(0));
    check("drain_novalid", 64'(instrValid),   64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Straight-line program with decode always ready.
    do_reset();
    load_prog(1'b0);
    instrReady = 1'b1;
    repeat (3) step();
    smp();
    check("idle_no_fetch", 64'(instrValid), 64'(0));
    check("idle_pc",       64'(imemAddr),   64'(0));
    step();
    exp_q.push_back({I0, 32'h0}); exp_q.push_back({I1, 32'h4}); exp_q.push_back({I2, 32'h8});
    exp_q.push_back({I3, 32'hC}); exp_q.push_back({EBRK, 32'h10});
    start = 1'b1;
    step();
    start = 1'b0;
    smp();
    check("lat_first_edge_valid", 64'(instrValid), 64'(0));
    check("lat_state_run",        64'(state_dbg),  64'(ST_RUN));
    smp();
    check("lat_second_edge_valid", 64'(instrValid), 64'(1));
    wait_halt(50);
    check("halt_addr_10", 64'(imemAddr), 64'(32'h10));
    wait_drain(50, 1'b0);

    // Decode stalled: buffer fills, PC sticks at 8, head held; then random-ready drain.
    do_reset();
    load_prog(1'b0);
    exp_q.push_back({I0, 32'h0}); exp_q.push_back({I1, 32'h4}); exp_q.push_back({I2, 32'h8});
    exp_q.push_back({I3, 32'hC}); exp_q.push_back({EBRK, 32'h10});
    start = 1'b1;
    step();
    start = 1'b0;
    smp();
    for (int i = 0; i < 5; i++) begin
      smp();
      check("stall_valid", 64'(instrValid),        64'(1));
      check("stall_hold",  64'({instr, instrPC}),  {I0, 32'h0});
    end
    check("stall_addr", 64'(imemAddr), 64'(32'h8));
    step();
    instrReady = 1'b1;
    wait_halt(80);
    wait_drain(200, 1'b1);

    // Redirect to C while entries 4 and 8 are buffered.
    do_reset();
    load_prog(1'b0);
    exp_q.push_back({I0, 32'h0});
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) smp();
    check("pre_redir_addr", 64'(imemAddr), 64'(32'h8));
    step();
    instrReady = 1'b1;
    step();
    instrReady = 1'b0; redirectValid = 1'b1; redirectPC = 32'hC;
    exp_q.push_back({I3, 32'hC}); exp_q.push_back({EBRK, 32'h10});
    smp();
    check("pre_redir_head", 64'({instrValid, instrPC}), 64'({1'b1, 32'h4}));
    check("pre_redir_pc",   64'(imemAddr),              64'(32'hC));
    step();
    redirectValid = 1'b0;
    smp();
    check("redir_flush_valid", 64'(instrValid), 64'(0));
    step();
    instrReady = 1'b1;
    wait_halt(30);
    wait_drain(30, 1'b0);

    // EBREAK at word 2, then redirect to 0 restarts fetch.
    do_reset();
    load_prog(1'b1);
    instrReady = 1'b1;
    exp_q.push_back({I0, 32'h0}); exp_q.push_back({I1, 32'h4}); exp_q.push_back({EBRK, 32'h8});
    start = 1'b1;
    step();
    start = 1'b0;
    wait_halt(30);
    check("ebrk_addr_hold", 64'(imemAddr), 64'(32'h8));
    wait_drain(30, 1'b0);
    check("ebrk_still_halt", 64'(halted), 64'(1));
    step();
    exp_q.push_back({I0, 32'h0}); exp_q.push_back({I1, 32'h4}); exp_q.push_back({EBRK, 32'h8});
    redirectValid = 1'b1; redirectPC = 32'h0;
    step();
    redirectValid = 1'b0;
    smp();
    check("restart_halted", 64'(halted),    64'(0));
    check("restart_state",  64'(state_dbg), 64'(ST_RUN));
    wait_halt(30);
    wait_drain(30, 1'b1);

    // Misaligned redirect target faults; later redirects are ignored.
    do_reset();
    load_prog(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) smp();
    step();
    redirectValid = 1'b1; redirectPC = 32'h6;
    step();
    redirectValid = 1'b0;
    smp();
    check("mis_fault_early", 64'(fault),      64'(0));
    check("mis_flushed",     64'(instrValid), 64'(0));
    smp();
    check("mis_fault", 64'(fault), 64'(1));
    step();
    instrReady = 1'b1; redirectValid = 1'b1; redirectPC = 32'h0;
    step();
    redirectValid = 1'b0;
    repeat (3) smp();
    check("fault_sticky",      64'(fault),      64'(1));
    check("fault_pc_hold",     64'(imemAddr),   64'(32'h6));
    check("fault_no_valid",    64'(instrValid), 64'(0));

    // Running off the end of memory: buffered words still drain after the fault.
    do_reset();
    load_prog(1'b0);
    exp_q.push_back({mem[254], 32'h3F8}); exp_q.push_back({mem[255], 32'h3FC});
    redirectValid = 1'b1; redirectPC = 32'h3F8;
    step();
    redirectValid = 1'b0;
    smp();
    check("end_fault_early", 64'(fault), 64'(0));
    repeat (3) smp();
    check("end_fault",      64'(fault),      64'(1));
    check("end_buffered",   64'(instrValid), 64'(1));
    step();
    instrReady = 1'b1;
    wait_drain(20, 1'b0);

    // Redirect straight to 4*IMEM_WORDS from idle.
    do_reset();
    redirectValid = 1'b1; redirectPC = 32'd4 * IMEM_WORDS;
    step();
    redirectValid = 1'b0;
    smp();
    check("oob_state_run", 64'(state_dbg), 64'(ST_RUN));
    smp();
    check("oob_fault", 64'(fault), 64'(1));

    // Reset asserted mid-stream with the buffer full (do_reset checks outputs).
    do_reset();
    load_prog(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) smp();
    check("pre_rst_valid", 64'(instrValid), 64'(1));
    check("pre_rst_addr",  64'(imemAddr),   64'(32'h8));
    do_reset();
    repeat (2) step();
    smp();
    check("post_rst_idle", 64'(state_dbg), 64'(ST_IDLE));
    check("final_queue",   64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
